// File: rtl/mmuart_pkg.sv
// Shared state encodings and oversampling constants for the mmuart core.
// Optional parity state exists only when MMUART_PARITY_EN is defined.
package mmuart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef MMUART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef MMUART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/mmuart_baudgen.sv
// Oversampling tick source: one-cycle tick every max(divisor,1) sys_clk cycles.
// A divisor change takes effect at the next reload; no backpressure.
module mmuart_baudgen #(
  parameter int DIV_W = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [DIV_W-1:0] divisor,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d, reload;

  assign reload = (divisor == '0) ? '0 : divisor - 1'b1;
  assign tick   = (cnt_q == '0);
  assign cnt_d  = tick ? reload : cnt_q - 1'b1;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mmuart_core_gen.sv
// UART transceiver, 16x oversampled RX/TX sharing one baud tick; rx_done one cycle after stop sample.
// tx_wr is dropped while tx_busy; optional parity bit enabled by MMUART_PARITY_EN.
module mmuart_core_gen
  import mmuart_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DIV_W     = 16,
  parameter int STOP_BITS = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              uart_rx,
  output logic              uart_tx,
  input  logic [DIV_W-1:0]  divisor,
  input  logic              parity_odd,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_done,
  output logic              rx_frame_err,
  output logic              rx_parity_err,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_wr,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam logic [3:0] CNT_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] CNT_MID  = 4'(MID_SAMPLE);
  localparam logic [2:0] BIT_LAST = 3'(DATA_W - 1);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

  logic tick;

  mmuart_baudgen #(.DIV_W(DIV_W)) u_baudgen (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .divisor  (divisor),
    .tick     (tick)
  );

  // ---------------- receiver ----------------
  logic              rx_meta_q, rx_s_q;
  rx_state_t         rx_state_q, rx_state_d;
  logic [3:0]        rx_cnt_q, rx_cnt_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic              rx_done_q, rx_done_d, rx_ferr_q, rx_ferr_d;
  logic              rx_perr_q, rx_perr_d, rx_par_bad_q, rx_par_bad_d;

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_data_d    = rx_data_q;
    rx_done_d    = 1'b0;
    rx_ferr_d    = rx_ferr_q;
    rx_perr_d    = rx_perr_q;
    rx_par_bad_d = rx_par_bad_q;
    case (rx_state_q)
      RX_IDLE: if (tick && !rx_s_q) begin
        rx_state_d = RX_START;
        rx_cnt_d   = '0;
      end
      RX_START: if (tick) begin
        if (rx_cnt_q == CNT_MID) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 4'd1;
        end
      end
      RX_DATA: if (tick) begin
        rx_cnt_d = rx_cnt_q + 4'd1;
        if (rx_cnt_q == CNT_LAST) begin
          rx_shift_d = {rx_s_q, rx_shift_q[DATA_W-1:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == BIT_LAST) begin
`ifdef MMUART_PARITY_EN
            rx_state_d = RX_PARITY;
`else
            rx_state_d = RX_STOP;
`endif
          end
        end
      end
`ifdef MMUART_PARITY_EN
      RX_PARITY: if (tick) begin
        rx_cnt_d = rx_cnt_q + 4'd1;
        if (rx_cnt_q == CNT_LAST) begin
          rx_par_bad_d = rx_s_q ^ (^rx_shift_q) ^ parity_odd;
          rx_state_d   = RX_STOP;
        end
      end
`endif
      RX_STOP: if (tick) begin
        rx_cnt_d = rx_cnt_q + 4'd1;
        if (rx_cnt_q == CNT_LAST) begin
          rx_data_d  = rx_shift_q;
          rx_done_d  = 1'b1;
          rx_ferr_d  = !rx_s_q;
          rx_perr_d  = rx_par_bad_q;
          // A held-low line (break) must return high before a new start is hunted
          rx_state_d = rx_s_q ? RX_IDLE : RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: if (rx_s_q) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_data_q    <= '0;
      rx_done_q    <= 1'b0;
      rx_ferr_q    <= 1'b0;
      rx_perr_q    <= 1'b0;
      rx_par_bad_q <= 1'b0;
    end else begin
      rx_meta_q    <= uart_rx;
      rx_s_q       <= rx_meta_q;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_data_q    <= rx_data_d;
      rx_done_q    <= rx_done_d;
      rx_ferr_q    <= rx_ferr_d;
      rx_perr_q    <= rx_perr_d;
      rx_par_bad_q <= rx_par_bad_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_done      = rx_done_q;
  assign rx_frame_err = rx_ferr_q;
`ifdef MMUART_PARITY_EN
  assign rx_parity_err = rx_perr_q;
`else
  logic unused_parity;
  assign unused_parity = parity_odd ^ rx_perr_q;
  assign rx_parity_err = 1'b0;
`endif

  // ---------------- transmitter ----------------
  tx_state_t         tx_state_q, tx_state_d;
  logic [3:0]        tx_cnt_q, tx_cnt_d;
  logic [2:0]        tx_bit_q, tx_bit_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic              tx_par_q, tx_par_d, tx_stop_q, tx_stop_d;
  logic              tx_done_q, tx_done_d, tx_line_q, tx_line_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_stop_d  = tx_stop_q;
    tx_done_d  = 1'b0;
    case (tx_state_q)
      TX_IDLE: if (tx_wr) begin
        tx_state_d = TX_START;
        tx_shift_d = tx_data;
        tx_par_d   = (^tx_data) ^ parity_odd;
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_stop_d  = 1'b0;
      end
      TX_START: if (tick) begin
        tx_cnt_d = tx_cnt_q + 4'd1;
        if (tx_cnt_q == CNT_LAST) tx_state_d = TX_DATA;
      end
      TX_DATA: if (tick) begin
        tx_cnt_d = tx_cnt_q + 4'd1;
        if (tx_cnt_q == CNT_LAST) begin
          tx_shift_d = tx_shift_q >> 1;
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == BIT_LAST) begin
`ifdef MMUART_PARITY_EN
            tx_state_d = TX_PARITY;
`else
            tx_state_d = TX_STOP;
`endif
          end
        end
      end
`ifdef MMUART_PARITY_EN
      TX_PARITY: if (tick) begin
        tx_cnt_d = tx_cnt_q + 4'd1;
        if (tx_cnt_q == CNT_LAST) tx_state_d = TX_STOP;
      end
`endif
      TX_STOP: if (tick) begin
        tx_cnt_d = tx_cnt_q + 4'd1;
        if (tx_cnt_q == CNT_LAST) begin
          if (tx_stop_q == STOP_LAST) begin
            tx_state_d = TX_IDLE;
            tx_done_d  = 1'b1;
          end else begin
            tx_stop_d = 1'b1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    // Line level is registered from the next state so the pad never sees decode glitches
    case (tx_state_d)
      TX_START:  tx_line_d = 1'b0;
      TX_DATA:   tx_line_d = tx_shift_d[0];
`ifdef MMUART_PARITY_EN
      TX_PARITY: tx_line_d = tx_par_d;
`endif
      default:   tx_line_d = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_stop_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_stop_q  <= tx_stop_d;
      tx_done_q  <= tx_done_d;
      tx_line_q  <= tx_line_d;
    end
  end

  assign uart_tx = tx_line_q;
  assign tx_busy = (tx_state_q != TX_IDLE);
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_mmuart_core_gen.sv
// Scoreboarded bench: loopback frames, hand-driven RX frames, glitch/break, 2-stop timing, mid-frame reset.
module tb_mmuart_core_gen;

`ifdef MMUART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int BITC = 64;  // cycles per bit at divisor 4

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] divisor;
  logic        parity_odd;
  logic        line_sel, drv_rx;

  logic       uart_rx, uart_tx, rx_done, rx_frame_err, rx_parity_err, tx_wr, tx_busy, tx_done;
  logic [7:0] rx_data, tx_data;
  logic       uart_rx2, uart_tx2, rx_done2, rx_frame_err2, rx_parity_err2, tx_wr2, tx_busy2, tx_done2;
  logic [7:0] rx_data2, tx_data2;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  int   vectors = 0;
  int   miscompares = 0;
  int   rxd_cnt = 0;
  int   txd_cnt = 0;

  always #5 clk = ~clk;

  assign uart_rx  = line_sel ? drv_rx : uart_tx;
  assign uart_rx2 = uart_tx2;

  mmuart_core_gen #(.DATA_W(8), .DIV_W(16), .STOP_BITS(1)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .divisor(divisor), .parity_odd(parity_odd), .rx_data(rx_data), .rx_done(rx_done),
    .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err), .tx_data(tx_data),
    .tx_wr(tx_wr), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  mmuart_core_gen #(.DATA_W(8), .DIV_W(16), .STOP_BITS(2)) dut2 (
    .sys_clk(clk), .sys_rst_n(rst_n), .uart_rx(uart_rx2), .uart_tx(uart_tx2),
    .divisor(divisor), .parity_odd(parity_odd), .rx_data(rx_data2), .rx_done(rx_done2),
    .rx_frame_err(rx_frame_err2), .rx_parity_err(rx_parity_err2), .tx_data(tx_data2),
    .tx_wr(tx_wr2), .tx_busy(tx_busy2), .tx_done(tx_done2)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic fe, input logic pe);
    exp_t e;
    e.d  = d;
    e.fe = fe;
    e.pe = pe;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rx_done) begin
      rxd_cnt++;
      if (q1.size() == 0) check_eq("rx1_spurious", 1, 0);
      else begin
        e1 = q1.pop_front();
        check_eq("rx1_data", int'(rx_data), int'(e1.d));
        check_eq("rx1_ferr", int'(rx_frame_err), int'(e1.fe));
        check_eq("rx1_perr", int'(rx_parity_err), int'(e1.pe));
      end
    end
    if (rx_done2) begin
      if (q2.size() == 0) check_eq("rx2_spurious", 1, 0);
      else begin
        e2 = q2.pop_front();
        check_eq("rx2_data", int'(rx_data2), int'(e2.d));
        check_eq("rx2_ferr", int'(rx_frame_err2), int'(e2.fe));
      end
    end
    if (tx_done) txd_cnt++;
  end

  task automatic drive_bits(input logic v, input int nbits);
    drv_rx = v;
    repeat (nbits * BITC) @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic par, input logic stp);
    drive_bits(1'b0, 1);
    for (int i = 0; i < 8; i++) drive_bits(d[i], 1);
    if (PB == 1) drive_bits(par, 1);
    drive_bits(stp, 1);
  endtask

  // Tick phase relative to the write is free, so the length is rounded up to a whole tick period
  task automatic tx1_frame(input logic [7:0] d, input string tag);
    int  n;
    int  drops;
    bit  done;
    q1.push_back(mk(d, 1'b0, 1'b0));
    @(posedge clk); #1;
    tx_data = d;
    tx_wr   = 1'b1;
    @(posedge clk); #1;
    tx_wr = 1'b0;
    check_eq({tag, "_busy_start"}, int'(tx_busy), 1);
    n = 0; drops = 0; done = 0;
    while (!done && n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (tx_done) done = 1;
      else if (!tx_busy) drops++;
    end
    check_eq({tag, "_done_seen"}, int'(done), 1);
    check_eq({tag, "_len"}, ((n + 3) / 4) * 4, (10 + PB) * BITC);
    check_eq({tag, "_busy_held"}, drops, 0);
    check_eq({tag, "_busy_end"}, int'(tx_busy), 0);
    repeat (8) @(posedge clk);
    #1;
    check_eq({tag, "_rx_seen"}, q1.size(), 0);
  endtask

  initial begin
    int         n;
    int         rxd0, txd0;
    bit         done;
    logic [7:0] pat [4];
    pat[0] = 8'hA5; pat[1] = 8'h00; pat[2] = 8'hFF; pat[3] = 8'h5A;

    rst_n = 1'b0; divisor = 16'd4; parity_odd = 1'b0;
    line_sel = 1'b0; drv_rx = 1'b1;
    tx_wr = 1'b0; tx_data = '0; tx_wr2 = 1'b0; tx_data2 = '0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("rst_uart_tx", int'(uart_tx), 1);
    check_eq("rst_tx_busy", int'(tx_busy), 0);
    check_eq("rst_tx_done", int'(tx_done), 0);
    check_eq("rst_rx_done", int'(rx_done), 0);
    check_eq("rst_rx_data", int'(rx_data), 0);
    check_eq("rst_rx_ferr", int'(rx_frame_err), 0);
    check_eq("rst_rx_perr", int'(rx_parity_err), 0);
    check_eq("rst_uart_tx2", int'(uart_tx2), 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);

    // loopback patterns
    for (int i = 0; i < 4; i++) tx1_frame(pat[i], "lb");

    // two stop bits: dropped write while busy, then write on the tx_done cycle
    q2.push_back(mk(8'h3C, 1'b0, 1'b0));
    @(posedge clk); #1;
    tx_data2 = 8'h3C; tx_wr2 = 1'b1;
    @(posedge clk); #1;
    tx_wr2 = 1'b0;
    n = 0; done = 0;
    while (!done && n < 3000) begin
      @(posedge clk); #1;
      n++;
      tx_wr2 = 1'b0;
      if (tx_done2) done = 1;
      else if (n == 100) begin
        tx_data2 = 8'hFF;
        tx_wr2   = 1'b1;
      end
    end
    check_eq("s2_done_seen", int'(done), 1);
    check_eq("s2_len", ((n + 3) / 4) * 4, (11 + PB) * BITC);
    check_eq("s2_busy_end", int'(tx_busy2), 0);
    q2.push_back(mk(8'h96, 1'b0, 1'b0));
    tx_data2 = 8'h96; tx_wr2 = 1'b1;
    @(posedge clk); #1;
    tx_wr2 = 1'b0;
    check_eq("s2_b2b_busy", int'(tx_busy2), 1);
    n = 0; done = 0;
    while (!done && n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (tx_done2) done = 1;
    end
    check_eq("s2_b2b_len", ((n + 3) / 4) * 4, (11 + PB) * BITC);
    repeat (8) @(posedge clk);
    #1;
    check_eq("s2_rx_seen", q2.size(), 0);

    // short start glitch: 3 ticks low
    rxd0 = rxd_cnt;
    line_sel = 1'b1; drv_rx = 1'b1;
    repeat (10) @(posedge clk);
    #1 drv_rx = 1'b0;
    repeat (12) @(posedge clk);
    #1 drv_rx = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    check_eq("glitch_no_done", rxd_cnt - rxd0, 0);

    // break: 0x00 with stop low, line held low 40 bit times
    rxd0 = rxd_cnt;
    q1.push_back(mk(8'h00, 1'b1, 1'b0));
    drive_bits(1'b0, 40);
    check_eq("brk_one_done", rxd_cnt - rxd0, 1);
    check_eq("brk_ferr_held", int'(rx_frame_err), 1);
    check_eq("brk_data_held", int'(rx_data), 0);
    drive_bits(1'b1, 2);
    check_eq("brk_no_retrig", rxd_cnt - rxd0, 1);
    q1.push_back(mk(8'hC3, 1'b0, 1'b0));
    drive_frame(8'hC3, (^8'hC3) ^ parity_odd, 1'b1);
    drive_bits(1'b1, 1);
    check_eq("brk_recover", rxd_cnt - rxd0, 2);
    check_eq("brk_ferr_clear", int'(rx_frame_err), 0);

`ifdef MMUART_PARITY_EN
    parity_odd = 1'b1;
    line_sel   = 1'b0;
    tx1_frame(8'h01, "par_lb");
    line_sel = 1'b1;
    q1.push_back(mk(8'h01, 1'b0, 1'b1));
    drive_frame(8'h01, 1'b1, 1'b1);
    drive_bits(1'b1, 1);
    check_eq("par_err_held", int'(rx_parity_err), 1);
    q1.push_back(mk(8'h01, 1'b0, 1'b0));
    drive_frame(8'h01, 1'b0, 1'b1);
    drive_bits(1'b1, 1);
    check_eq("par_ok_clear", int'(rx_parity_err), 0);
    parity_odd = 1'b0;
`endif

    // reset in the middle of a TX data bit
    line_sel = 1'b0;
    @(posedge clk); #1;
    tx_data = 8'h81; tx_wr = 1'b1;
    @(posedge clk); #1;
    tx_wr = 1'b0;
    repeat (3 * BITC + 20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_uart_tx", int'(uart_tx), 1);
    check_eq("arst_tx_busy", int'(tx_busy), 0);
    check_eq("arst_tx_done", int'(tx_done), 0);
    txd0 = txd_cnt; rxd0 = rxd_cnt;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (1000) @(posedge clk);
    #1;
    check_eq("arst_no_tx_done", txd_cnt - txd0, 0);
    check_eq("arst_no_rx_done", rxd_cnt - rxd0, 0);
    check_eq("arst_line_idle", int'(uart_tx), 1);

    check_eq("q1_drained", q1.size(), 0);
    check_eq("q2_drained", q2.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
